// File: rtl/vppts_pkg.sv
// Shared state encoding and default timing constants for the VPPTS sequencer.
package vppts_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PRECHG = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_ON     = 3'd3;
    localparam state_t ST_DISCHG = 3'd4;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_PRECHG_CYC  = 16;
    localparam int unsigned DEF_SETTLE_CYC  = 32;
    localparam int unsigned DEF_DISCHG_CYC  = 24;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/vppts_sync2.sv
// Two-flop synchronizer for the asynchronous level-detect comparator output.
module vppts_sync2 (
    input  logic clk,
    input  logic resb,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vppts_seq_ctrl.sv
// VPPTS switch sequencer: precharge -> settle -> on -> discharge, with level-detect
// monitoring, timeout and sticky error reporting. All outputs registered.
module vppts_seq_ctrl
    import vppts_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PRECHG_CYC  = DEF_PRECHG_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned DISCHG_CYC  = DEF_DISCHG_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic resb,
    input  logic req,
    input  logic abort,
    input  logic errclr,
    input  logic detok,
    output logic vpptspre,
    output logic vpptsen,
    output logic vpptsdis,
    output logic ack,
    output logic busy,
    output logic err
);

    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRECHG_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LD   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DIS_LD   = CNT_W'(DISCHG_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic              err_q, err_d, err_set;
    logic              det_s;
    logic              pre_q, en_q, dis_q, ack_q, busy_q;

    vppts_sync2 u_sync (
        .clk  (clk),
        .resb (resb),
        .d    (detok),
        .q    (det_s)
    );

    // Per-cycle priority: abort, then error detection, then request drop, then progress.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !err_q) state_d = ST_PRECHG;
            end
            ST_PRECHG: begin
                if (abort || !req)       state_d = ST_DISCHG;
                else if (cnt_q == '0)    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_DISCHG;
                end else if (tcnt_q == TMO_LAST) begin
                    err_set = 1'b1;
                    state_d = ST_DISCHG;
                end else if (!req) begin
                    state_d = ST_DISCHG;
                end else if (cnt_q == '0 && det_s) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (abort) begin
                    state_d = ST_DISCHG;
                end else if (!det_s) begin
                    err_set = 1'b1;
                    state_d = ST_DISCHG;
                end else if (!req) begin
                    state_d = ST_DISCHG;
                end
            end
            ST_DISCHG: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shared phase counter loads only on a state change, so abort in DISCHG never restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_PRECHG: cnt_d = PRE_LD;
                ST_SETTLE: cnt_d = SET_LD;
                ST_DISCHG: cnt_d = DIS_LD;
                default:   cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
            tcnt_d = '0;
        end else if (state_q == ST_SETTLE && tcnt_q != TMO_LAST) begin
            tcnt_d = tcnt_q + ONE;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_set)     err_d = 1'b1;
        else if (errclr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            pre_q   <= 1'b0;
            en_q    <= 1'b0;
            dis_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            pre_q   <= (state_d == ST_PRECHG);
            en_q    <= (state_d == ST_SETTLE) || (state_d == ST_ON);
            dis_q   <= (state_d == ST_DISCHG);
            ack_q   <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign vpptspre = pre_q;
    assign vpptsen  = en_q;
    assign vpptsdis = dis_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
